// File: rtl/parking_slot_timestamp.sv
// parking_slot_timestamp
//   Front end for the 8-bit elapsed-time subtractor. Keeps a free-running
//   8-bit time base and a table of per-slot entry stamps. An entry request
//   allocates and stamps the lowest free slot. An exit request frees a slot
//   and presents its entry/exit stamps as a time_in/time_out pair with a
//   one-cycle pair_valid strobe.
//
//   Optional feature macro: PARK_TICK_PRESCALER_EN
//     defined   : time base advances once every TICK_DIV clocks
//     undefined : time base advances every clock (TICK_DIV unused)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   entry_req             level request, held until entry_ack
//   entry_ack/entry_err   one-cycle ack; err=1 means the table was full
//   entry_slot            allocated slot, valid with ack when err=0
//   exit_req, exit_slot   level request and slot to vacate
//   exit_ack/exit_err     one-cycle ack; err=1 means empty/out-of-range slot
//   time_in, time_out     entry stamp and exit time of the vacated slot
//   pair_valid            one-cycle strobe for the subtractor
//   time_now              current time base
//   occupancy, full       number of occupied slots, occupancy == SLOTS
module parking_slot_timestamp #(
  parameter int unsigned SLOTS    = 8,
  parameter int unsigned SLOT_W   = 3,
  parameter int unsigned TICK_DIV = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              entry_req,
  output logic              entry_ack,
  output logic              entry_err,
  output logic [SLOT_W-1:0] entry_slot,
  input  logic              exit_req,
  input  logic [SLOT_W-1:0] exit_slot,
  output logic              exit_ack,
  output logic              exit_err,
  output logic [7:0]        time_in,
  output logic [7:0]        time_out,
  output logic              pair_valid,
  output logic [7:0]        time_now,
  output logic [SLOT_W:0]   occupancy,
  output logic              full
);

  localparam int unsigned NIDX = 1 << SLOT_W;

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_EXIT, S_WAIT_LOW} state_e;

  state_e            state_q;
  logic              svc_exit_q;
  logic [SLOTS-1:0]  valid_q;
  logic [7:0]        stamp_q [SLOTS];
  logic [SLOT_W:0]   occ_q;
  logic [7:0]        time_q, time_d;
  logic              tick;

  logic              entry_ack_q, entry_err_q, exit_ack_q, exit_err_q, pair_valid_q;
  logic [SLOT_W-1:0] entry_slot_q;
  logic [7:0]        time_in_q, time_out_q;

  logic              full_w;
  logic [SLOT_W-1:0] free_idx;
  logic [NIDX-1:0]   valid_ext;
  logic              exit_hit;
  logic              stamp_we;

  // ---------------- time base ----------------
`ifdef PARK_TICK_PRESCALER_EN
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] presc_q, presc_d;

  always_comb begin
    tick    = (presc_q == PW'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_d;
  end
`else
  // One tick per clock; TICK_DIV has no effect in this build.
  logic unused_tick_div;
  always_comb unused_tick_div = (TICK_DIV == 0);
  always_comb tick = 1'b1;
`endif

  always_comb time_d = time_q + {7'd0, tick};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) time_q <= '0;
    else        time_q <= time_d;
  end

  // ---------------- slot lookup ----------------
  always_comb full_w = (occ_q == (SLOT_W + 1)'(SLOTS));

  // Scan downward so the lowest free index is the one left standing.
  always_comb begin
    free_idx = '0;
    for (int unsigned i = SLOTS; i > 0; i--) begin
      if (!valid_q[i-1]) free_idx = SLOT_W'(i - 1);
    end
  end

  // Indices at or above SLOTS read as empty, which folds the range check
  // into the valid lookup.
  always_comb begin
    valid_ext = NIDX'(valid_q);
    exit_hit  = valid_ext[exit_slot];
  end

  // Stamps carry no reset: they are only reachable through a set valid bit.
  always_comb stamp_we = (state_q == S_ENTRY) && !full_w;

  always_ff @(posedge clk) begin
    if (stamp_we) stamp_q[free_idx] <= time_q;
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      svc_exit_q   <= 1'b0;
      valid_q      <= '0;
      occ_q        <= '0;
      entry_ack_q  <= 1'b0;
      entry_err_q  <= 1'b0;
      entry_slot_q <= '0;
      exit_ack_q   <= 1'b0;
      exit_err_q   <= 1'b0;
      pair_valid_q <= 1'b0;
      time_in_q    <= '0;
      time_out_q   <= '0;
    end else begin
      entry_ack_q  <= 1'b0;
      entry_err_q  <= 1'b0;
      exit_ack_q   <= 1'b0;
      exit_err_q   <= 1'b0;
      pair_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (exit_req)       state_q <= S_EXIT;
          else if (entry_req) state_q <= S_ENTRY;
        end
        S_ENTRY: begin
          entry_ack_q <= 1'b1;
          if (full_w) begin
            entry_err_q <= 1'b1;
          end else begin
            valid_q[free_idx] <= 1'b1;
            entry_slot_q      <= free_idx;
            occ_q             <= occ_q + 1'b1;
          end
          svc_exit_q <= 1'b0;
          state_q    <= S_WAIT_LOW;
        end
        S_EXIT: begin
          exit_ack_q <= 1'b1;
          if (exit_hit) begin
            valid_q[exit_slot] <= 1'b0;
            time_in_q          <= stamp_q[exit_slot];
            time_out_q         <= time_q;
            pair_valid_q       <= 1'b1;
            occ_q              <= occ_q - 1'b1;
          end else begin
            exit_err_q <= 1'b1;
          end
          svc_exit_q <= 1'b1;
          state_q    <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (svc_exit_q ? !exit_req : !entry_req) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign entry_ack  = entry_ack_q;
  assign entry_err  = entry_err_q;
  assign entry_slot = entry_slot_q;
  assign exit_ack   = exit_ack_q;
  assign exit_err   = exit_err_q;
  assign pair_valid = pair_valid_q;
  assign time_in    = time_in_q;
  assign time_out   = time_out_q;
  assign time_now   = time_q;
  assign occupancy  = occ_q;
  assign full       = full_w;

endmodule

// File: tb/tb_parking_slot_timestamp.sv
// Bench for parking_slot_timestamp: expected acks are queued when a request
// is driven and compared when the DUT acknowledges it.
module tb_parking_slot_timestamp;

  localparam int unsigned SLOTS = 8;
  localparam int unsigned SW    = 3;
  localparam int unsigned TDIV  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          entry_req = 1'b0;
  logic          exit_req = 1'b0;
  logic [SW-1:0] exit_slot = '0;
  logic          entry_ack, entry_err, exit_ack, exit_err, pair_valid, full;
  logic [SW-1:0] entry_slot;
  logic [7:0]    time_in, time_out, time_now;
  logic [SW:0]   occupancy;

  always #5 clk = ~clk;

  parking_slot_timestamp #(.SLOTS(SLOTS), .SLOT_W(SW), .TICK_DIV(TDIV)) dut (
    .clk(clk), .rst_n(rst_n),
    .entry_req(entry_req), .entry_ack(entry_ack), .entry_err(entry_err),
    .entry_slot(entry_slot),
    .exit_req(exit_req), .exit_slot(exit_slot), .exit_ack(exit_ack),
    .exit_err(exit_err), .time_in(time_in), .time_out(time_out),
    .pair_valid(pair_valid), .time_now(time_now),
    .occupancy(occupancy), .full(full)
  );

  int checks = 0;
  int passed = 0;

  typedef struct {
    bit          is_exit;
    bit          err;
    logic [SW-1:0] slot;
    logic [7:0]  tin;
  } exp_t;

  exp_t       sb[$];
  bit         mvalid [SLOTS];
  logic [7:0] mstamp [SLOTS];
  int         mocc;

  // Reference time base: m_prev is the value present before the latest edge,
  // i.e. the value a service on that edge captures.
  logic [7:0] m_time, m_prev;
`ifdef PARK_TICK_PRESCALER_EN
  int m_presc;
`endif
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_time <= '0;
      m_prev <= '0;
`ifdef PARK_TICK_PRESCALER_EN
      m_presc <= 0;
`endif
    end else begin
      m_prev <= m_time;
`ifdef PARK_TICK_PRESCALER_EN
      if (m_presc == TDIV - 1) begin
        m_presc <= 0;
        m_time  <= m_time + 8'd1;
      end else begin
        m_presc <= m_presc + 1;
      end
`else
      m_time <= m_time + 8'd1;
`endif
    end
  end

  // ---------------- model / stimulus helpers ----------------
  task automatic model_clear();
    for (int i = 0; i < SLOTS; i++) mvalid[i] = 1'b0;
    mocc = 0;
    sb.delete();
  endtask

  task automatic push_entry();
    exp_t e;
    e.is_exit = 1'b0; e.err = 1'b1; e.slot = '0; e.tin = '0;
    for (int i = SLOTS - 1; i >= 0; i--)
      if (!mvalid[i]) begin e.err = 1'b0; e.slot = SW'(i); end
    if (!e.err) begin mvalid[e.slot] = 1'b1; mocc++; end
    sb.push_back(e);
  endtask

  task automatic push_exit(input int s);
    exp_t e;
    e.is_exit = 1'b1; e.slot = SW'(s); e.tin = '0; e.err = 1'b1;
    if (s < SLOTS && mvalid[s]) begin
      e.err = 1'b0; e.tin = mstamp[s]; mvalid[s] = 1'b0; mocc--;
    end
    sb.push_back(e);
  endtask

  task automatic do_reset();
    entry_req = 1'b0; exit_req = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
  endtask

  task automatic wait_time(input logic [7:0] t);
    for (int i = 0; i < 1200 && m_time != t; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_entry(output bit got, output bit err,
                             output logic [SW-1:0] slot, output logic [7:0] stamp,
                             output bit again);
    got = 1'b0; err = 1'b0; slot = '0; stamp = '0;
    entry_req = 1'b1;
    for (int i = 0; i < 12 && !got; i++) begin
      @(posedge clk); #1;
      if (entry_ack) begin
        got = 1'b1; err = entry_err; slot = entry_slot; stamp = m_prev;
      end
    end
    entry_req = 1'b0;
    @(posedge clk); #1;
    again = entry_ack;
  endtask

  task automatic drive_exit(input int s, output bit got, output bit err,
                            output bit pv, output logic [7:0] tin,
                            output logic [7:0] tout, output logic [7:0] tref,
                            output bit again);
    got = 1'b0; err = 1'b0; pv = 1'b0; tin = '0; tout = '0; tref = '0;
    exit_slot = SW'(s);
    exit_req  = 1'b1;
    for (int i = 0; i < 12 && !got; i++) begin
      @(posedge clk); #1;
      if (exit_ack) begin
        got = 1'b1; err = exit_err; pv = pair_valid;
        tin = time_in; tout = time_out; tref = m_prev;
      end
    end
    exit_req = 1'b0;
    @(posedge clk); #1;
    again = exit_ack | pair_valid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({entry_ack, entry_err, entry_slot, exit_ack, exit_err, time_in, time_out,
         pair_valid, time_now, occupancy, full} !== '0)
      $display("FAIL reset_outputs: got ack=%b/%b err=%b/%b tnow=%0d occ=%0d full=%b, want all 0",
               entry_ack, exit_ack, entry_err, exit_err, time_now, occupancy, full);
    else passed++;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (time_now !== 8'd0) $display("FAIL reset_hold_time: got %0d want 0", time_now);
    else passed++;
  endtask

  task automatic test_entries();
    bit got, err, again; logic [SW-1:0] slot; logic [7:0] stamp; exp_t e;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      wait_time(8'(10 * n + 9));
      push_entry();
      drive_entry(got, err, slot, stamp, again);
      e = sb.pop_front();
      checks++;
      if (!got || err !== e.err || slot !== e.slot || again)
        $display("FAIL entry%0d: got ack=%b err=%b slot=%0d again=%b want ack=1 err=%b slot=%0d again=0",
                 n, got, err, slot, again, e.err, e.slot);
      else passed++;
      mstamp[e.slot] = stamp;
`ifndef PARK_TICK_PRESCALER_EN
      checks++;
      if (stamp !== 8'(10 * n + 10))
        $display("FAIL entry%0d_stamp_time: got %0d want %0d", n, stamp, 10 * n + 10);
      else passed++;
`endif
    end
    checks++;
    if (occupancy !== 4'(mocc) || full !== 1'b0)
      $display("FAIL entries_occ: got occ=%0d full=%b want occ=%0d full=0", occupancy, full, mocc);
    else passed++;
  endtask

  task automatic test_exit_pair();
    bit got, err, pv, again; logic [7:0] tin, tout, tref, stamp; logic [SW-1:0] slot; exp_t e;
    wait_time(8'd49);
    push_exit(1);
    drive_exit(1, got, err, pv, tin, tout, tref, again);
    e = sb.pop_front();
    checks++;
    if (!got || err !== e.err || !pv || tin !== e.tin || tout !== tref || again)
      $display("FAIL exit_pair: got ack=%b err=%b pv=%b tin=%0d tout=%0d again=%b want ack=1 err=0 pv=1 tin=%0d tout=%0d again=0",
               got, err, pv, tin, tout, again, e.tin, tref);
    else passed++;
`ifndef PARK_TICK_PRESCALER_EN
    checks++;
    if (tin !== 8'd20 || tout !== 8'd50)
      $display("FAIL exit_pair_values: got tin=%0d tout=%0d want 20/50", tin, tout);
    else passed++;
`endif
    push_entry();
    drive_entry(got, err, slot, stamp, again);
    e = sb.pop_front();
    mstamp[e.slot] = stamp;
    checks++;
    if (!got || err || slot !== e.slot || slot !== SW'(1))
      $display("FAIL reuse_slot: got ack=%b err=%b slot=%0d want ack=1 err=0 slot=1", got, err, slot);
    else passed++;
  endtask

  task automatic test_full();
    bit got, err, pv, again; logic [7:0] tin, tout, tref, stamp, tin0, tout0;
    logic [SW-1:0] slot; exp_t e;
    while (mocc < SLOTS) begin
      push_entry();
      drive_entry(got, err, slot, stamp, again);
      e = sb.pop_front();
      mstamp[e.slot] = stamp;
      checks++;
      if (!got || err !== e.err || slot !== e.slot)
        $display("FAIL fill_slot%0d: got ack=%b err=%b slot=%0d", e.slot, got, err, slot);
      else passed++;
    end
    push_entry();
    drive_entry(got, err, slot, stamp, again);
    e = sb.pop_front();
    checks++;
    if (!got || err !== 1'b1 || e.err !== 1'b1 || full !== 1'b1 || occupancy !== 4'd8)
      $display("FAIL entry_when_full: got ack=%b err=%b full=%b occ=%0d want ack=1 err=1 full=1 occ=8",
               got, err, full, occupancy);
    else passed++;
    push_exit(5);
    drive_exit(5, got, err, pv, tin0, tout0, tref, again);
    e = sb.pop_front();
    checks++;
    if (!got || err || !pv || tin0 !== e.tin || tout0 !== tref)
      $display("FAIL exit_slot5: got err=%b pv=%b tin=%0d tout=%0d want 0/1/%0d/%0d", err, pv, tin0, tout0, e.tin, tref);
    else passed++;
    push_exit(5);
    drive_exit(5, got, err, pv, tin, tout, tref, again);
    e = sb.pop_front();
    checks++;
    if (!got || err !== 1'b1 || e.err !== 1'b1 || pv !== 1'b0 || tin !== tin0 || tout !== tout0)
      $display("FAIL exit_empty: got ack=%b err=%b pv=%b tin=%0d tout=%0d want ack=1 err=1 pv=0 tin=%0d tout=%0d",
               got, err, pv, tin, tout, tin0, tout0);
    else passed++;
    checks++;
    if (occupancy !== 4'd7 || full !== 1'b0)
      $display("FAIL occ_after_exit: got occ=%0d full=%b want 7/0", occupancy, full);
    else passed++;
  endtask

  task automatic test_wrap();
    bit got, err, pv, again; logic [7:0] tin, tout, tref, stamp; logic [SW-1:0] slot; exp_t e;
    wait_time(8'd249);
    push_entry();
    drive_entry(got, err, slot, stamp, again);
    e = sb.pop_front();
    mstamp[e.slot] = stamp;
    checks++;
    if (!got || err || slot !== e.slot)
      $display("FAIL wrap_entry: got ack=%b err=%b slot=%0d want 1/0/%0d", got, err, slot, e.slot);
    else passed++;
    wait_time(8'd3);
    push_exit(int'(e.slot));
    drive_exit(int'(e.slot), got, err, pv, tin, tout, tref, again);
    e = sb.pop_front();
    checks++;
    if (!got || err || !pv || tin !== e.tin || tout !== tref)
      $display("FAIL wrap_exit: got err=%b pv=%b tin=%0d tout=%0d want 0/1/%0d/%0d", err, pv, tin, tout, e.tin, tref);
    else passed++;
`ifndef PARK_TICK_PRESCALER_EN
    checks++;
    if (tin !== 8'd250 || tout !== 8'd4 || 8'(tout - tin) !== 8'd10)
      $display("FAIL wrap_values: got tin=%0d tout=%0d diff=%0d want 250/4/10", tin, tout, 8'(tout - tin));
    else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    int n_x = 0, n_e = 0; exp_t e;
    push_exit(0);
    push_entry();
    exit_slot = '0;
    exit_req = 1'b1; entry_req = 1'b1;
    for (int n = 1; n <= 12 && (n_x == 0 || n_e == 0); n++) begin
      @(posedge clk); #1;
      if (exit_ack) begin
        n_x = n; e = sb.pop_front();
        checks++;
        if (!e.is_exit || exit_err !== e.err || pair_valid !== 1'b1 || time_in !== e.tin || n_e != 0)
          $display("FAIL b2b_exit: got err=%b pv=%b tin=%0d first_was_exit=%b want 0/1/%0d/1",
                   exit_err, pair_valid, time_in, e.is_exit, e.tin);
        else passed++;
        exit_req = 1'b0;
      end
      if (entry_ack) begin
        n_e = n; e = sb.pop_front();
        mstamp[e.slot] = m_prev;
        checks++;
        if (e.is_exit || entry_err !== e.err || entry_slot !== e.slot)
          $display("FAIL b2b_entry: got err=%b slot=%0d want %b/%0d", entry_err, entry_slot, e.err, e.slot);
        else passed++;
        entry_req = 1'b0;
      end
    end
    exit_req = 1'b0; entry_req = 1'b0;
    checks++;
    if (n_x != 2 || n_e != 5)
      $display("FAIL b2b_timing: got exit_ack@%0d entry_ack@%0d want 2/5", n_x, n_e);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_exit();
    bit got, err, pv, again; logic [7:0] tin, tout, tref; exp_t e;
    exit_slot = '0;
    exit_req = 1'b1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (exit_ack !== 1'b0 || pair_valid !== 1'b0 || occupancy !== '0 || time_now !== 8'd0)
      $display("FAIL reset_in_exit: got ack=%b pv=%b occ=%0d tnow=%0d want 0/0/0/0",
               exit_ack, pair_valid, occupancy, time_now);
    else passed++;
    exit_req = 1'b0;
    model_clear();
    @(posedge clk); #1;
    checks++;
    if (exit_ack !== 1'b0 || pair_valid !== 1'b0)
      $display("FAIL reset_in_exit_noack: got ack=%b pv=%b want 0/0", exit_ack, pair_valid);
    else passed++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    push_exit(0);
    drive_exit(0, got, err, pv, tin, tout, tref, again);
    e = sb.pop_front();
    checks++;
    if (!got || err !== 1'b1 || e.err !== 1'b1 || pv !== 1'b0)
      $display("FAIL exit_after_reset: got ack=%b err=%b pv=%b want 1/1/0", got, err, pv);
    else passed++;
  endtask

  task automatic test_prescaler();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checks++;
`ifdef PARK_TICK_PRESCALER_EN
    if (time_now !== 8'd3) $display("FAIL prescaler_time: got %0d want 3", time_now);
`else
    if (time_now !== 8'd12) $display("FAIL free_run_time: got %0d want 12", time_now);
`endif
    else passed++;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_entries();
    test_exit_pair();
    test_full();
    test_wrap();
    test_back_to_back();
    test_reset_mid_exit();
    test_prescaler();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
